// File: rtl/seq_deserializer.sv
// Serial-to-parallel word assembler for the generator's one-bit output stream.
// Completed words go to a single holding register on a valid/ready port; lost words set a sticky flag.
module seq_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  // Shift direction decides which end of the word the first bit ends up in.
  if (MSB_FIRST) begin : g_msb
    assign shifted = {sreg_q[WIDTH-2:0], bit_in};
  end else begin : g_lsb
    assign shifted = {bit_in, sreg_q[WIDTH-1:1]};
  end

  assign complete = bit_en && (cnt_q == LAST);

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q;
    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
      word_d = '0;
      vld_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (bit_en) begin
        sreg_d = shifted;
        cnt_d  = complete ? '0 : cnt_q + CNT_W'(1);
      end
      if (vld_q && word_ready) vld_d = 1'b0;
      // A completing word may reuse the holding slot if it drains on this same edge.
      if (complete) begin
        if (!vld_q || word_ready) begin
          word_d = shifted;
          vld_d  = 1'b1;
        end else begin
          ovf_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = vld_q;
  assign overflow   = ovf_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_seq_deserializer.sv
// Bench for seq_deserializer: MSB-first and LSB-first instances share one stimulus stream
// and are checked each cycle against a queue-based model, plus directed literal checks.
module tb_seq_deserializer;
  localparam int W = 8;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_in = 1'b0, bit_en = 1'b0, clear = 1'b0, word_ready = 1'b0;
  logic [W-1:0]  word_m, word_l;
  logic          vld_m, vld_l, ovf_m, ovf_l;
  logic [CW-1:0] cnt_m, cnt_l;

  always #5 clk = ~clk;

  seq_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en), .clear(clear),
    .word_out(word_m), .word_valid(vld_m), .word_ready(word_ready),
    .overflow(ovf_m), .bit_count(cnt_m));

  seq_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en), .clear(clear),
    .word_out(word_l), .word_valid(vld_l), .word_ready(word_ready),
    .overflow(ovf_l), .bit_count(cnt_l));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bits gathered in a queue, word built by positional weighting.
  bit       mbits[$];
  logic [W-1:0] mword_m = '0, mword_l = '0;
  logic     mvld = 1'b0, movf = 1'b0;

  task automatic model_step();
    logic [W-1:0] wm, wl;
    if (!reset || clear) begin
      mbits.delete();
      mword_m = '0; mword_l = '0; mvld = 1'b0; movf = 1'b0;
      return;
    end
    if (mvld && word_ready) mvld = 1'b0;
    if (bit_en) begin
      mbits.push_back(bit_in);
      if (mbits.size() == W) begin
        wm = '0; wl = '0;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = mbits[i];
          wl[i]     = mbits[i];
        end
        mbits.delete();
        if (!mvld) begin
          mword_m = wm; mword_l = wl; mvld = 1'b1;
        end else begin
          movf = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  // Per-cycle comparison on the inactive edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("word_msb", word_m, mword_m);
      chk("word_lsb", word_l, mword_l);
      chk("valid_msb", vld_m, mvld);
      chk("valid_lsb", vld_l, mvld);
      chk("ovf_msb", ovf_m, movf);
      chk("ovf_lsb", ovf_l, movf);
      chk("cnt_msb", cnt_m, mbits.size());
      chk("cnt_lsb", cnt_l, mbits.size());
    end
  end

  task automatic tick(input logic b, input logic en, input logic rdy, input logic clr);
    @(negedge clk);
    bit_in = b; bit_en = en; word_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic rdy);
    for (int i = W - 1; i >= 0; i--) tick(v[i], 1'b1, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] v;
    repeat (3) @(negedge clk);
    chk("reset_valid", vld_m, 1'b0);
    chk("reset_cnt", cnt_m, 0);
    chk("reset_word", word_m, 0);
    reset = 1'b1;

    // 1,0,1,0,0,1,0,1 -> 0xA5 both orders; valid for one cycle only.
    send_word(8'hA5, 1'b1);
    chk("a5_msb", word_m, 8'hA5);
    chk("a5_lsb", word_l, 8'hA5);
    chk("a5_model", mword_m, 8'hA5);
    chk("a5_valid", vld_m, 1'b1);
    chk("a5_cnt", cnt_m, 0);
    idle(1, 1'b1);
    chk("a5_valid_drop", vld_m, 1'b0);

    // 1,1,0,0,0,0,0,0 -> 0x03 LSB-first, 0xC0 MSB-first.
    send_word(8'hC0, 1'b1);
    chk("c0_lsb", word_l, 8'h03);
    chk("c0_model_lsb", mword_l, 8'h03);
    chk("c0_msb", word_m, 8'hC0);

    // 0xF0 with bit_en gaps after bits 2 and 5.
    v = 8'hF0;
    for (int i = W - 1; i >= 0; i--) begin
      tick(v[i], 1'b1, 1'b1, 1'b0);
      if (i == 6) begin idle(3, 1'b1); chk("gap_cnt2", cnt_m, 2); end
      if (i == 3) begin idle(3, 1'b1); chk("gap_cnt5", cnt_l, 5); end
    end
    chk("f0_msb", word_m, 8'hF0);

    // Back-pressure: second word dropped, overflow sticks.
    idle(1, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("bp_word", word_m, 8'h11);
    chk("bp_valid", vld_m, 1'b1);
    chk("bp_ovf", ovf_m, 1'b1);
    idle(1, 1'b1);
    chk("bp_drain", vld_m, 1'b0);
    send_word(8'h33, 1'b0);
    chk("bp_33", word_m, 8'h33);
    chk("bp_ovf_sticky", ovf_l, 1'b1);

    // Drain and complete on the same edge.
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_ovf", ovf_m, 1'b0);
    send_word(8'h44, 1'b0);
    v = 8'h55;
    for (int i = W - 1; i >= 0; i--) tick(v[i], 1'b1, (i == 0), 1'b0);
    chk("sim_word", word_m, 8'h55);
    chk("sim_valid", vld_m, 1'b1);
    chk("sim_ovf", ovf_m, 1'b0);

    // Asynchronous reset mid-word.
    v = 8'h9A;
    for (int i = W - 1; i >= W - 4; i--) tick(v[i], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bit_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt", cnt_m, 0);
    chk("arst_valid", vld_m, 1'b0);
    #1 reset = 1'b1;
    send_word(8'h6C, 1'b1);
    chk("arst_6c", word_m, 8'h6C);

    // Clear mid-word, with overflow set beforehand.
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    for (int i = W - 1; i >= W - 5; i--) tick(v[i], 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt", cnt_m, 0);
    chk("clr_valid", vld_m, 1'b0);
    chk("clr_ovf2", ovf_m, 1'b0);
    chk("clr_word", word_m, 0);
    send_word(8'h6C, 1'b1);
    chk("clr_6c", word_m, 8'h6C);
    chk("clr_6c_lsb", word_l, 8'h36);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
      tick(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0 ? 1'($urandom) : 1'b0),
           ($urandom_range(0, 99) == 0));
    end
    idle(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
